// File: rtl/cpu16_pkg.sv
// Shared encodings for the cpu16 multi-cycle sequencer: opcodes, ALU classes,
// trap causes, FSM states and the decoded control bundle.
package cpu16_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_MUL   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_LW    = 4'h8;
  localparam logic [3:0] OP_SW    = 4'hC;
  localparam logic [3:0] OP_BEQ   = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_BUS     = 2'b10;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} ctrlStateT;

  typedef struct packed {
    logic       regDst;
    logic       branch;
    logic       memToReg;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       is_mem;
    logic       is_load;
    logic       is_branch;
    logic       is_mul;
    logic       writes_reg;
    logic       illegal;
  } decodeT;

endpackage

// File: rtl/cpu16_main_decoder.sv
// Combinational opcode decoder: level controls plus instruction-class flags.
// HALT decodes to an all-zero, legal bundle; unknown opcodes raise illegal.
module cpu16_main_decoder
  import cpu16_pkg::*;
(
  input  logic [3:0] opcode,
  output decodeT     dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.regDst     = 1'b1;
        dec.aluOp      = ALUOP_FUNCT;
        dec.writes_reg = 1'b1;
      end
      OP_MUL: begin
        dec.regDst     = 1'b1;
        dec.aluOp      = ALUOP_FUNCT;
        dec.is_mul     = 1'b1;
        dec.writes_reg = 1'b1;
      end
      OP_ADDI: begin
        dec.aluSrc     = 1'b1;
        dec.aluOp      = ALUOP_ADD;
        dec.writes_reg = 1'b1;
      end
      OP_LW: begin
        dec.aluSrc     = 1'b1;
        dec.memToReg   = 1'b1;
        dec.aluOp      = ALUOP_ADD;
        dec.is_mem     = 1'b1;
        dec.is_load    = 1'b1;
        dec.writes_reg = 1'b1;
      end
      OP_SW: begin
        dec.aluSrc = 1'b1;
        dec.aluOp  = ALUOP_ADD;
        dec.is_mem = 1'b1;
      end
      OP_BEQ: begin
        dec.branch    = 1'b1;
        dec.aluOp     = ALUOP_SUB;
        dec.is_branch = 1'b1;
      end
      OP_HALT: dec = '0;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu16_multicycle_ctrl.sv
// Multi-cycle sequencer for the 16-bit datapath: owns PC/IR, fetches over a
// ready handshake, drives datapath controls and handles halt/trap/timeout.
module cpu16_multicycle_ctrl
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  MAX_WAIT = 8'd255
) (
  input  logic        Clock,
  input  logic        ResetN,
  output logic        ImemReq,
  output logic [15:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [15:0] ImemData,
  output logic [15:0] Instruction,
  output logic [15:0] PC,
  input  logic        Zero,
  input  logic [15:0] BranchTarget,
  input  logic        DmemReady,
  output logic        RegDst,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MulRegWrite,
  output logic [1:0]  ALUOp,
  output logic        Halted,
  output logic        Trap,
  output logic [1:0]  TrapCause,
  output logic [15:0] RetiredCount
);

  ctrlStateT   state, stateNext;
  logic [15:0] pcReg, irReg, retiredCnt, pcNext;
  logic [7:0]  waitCnt, waitNext, waitInc;
  logic [1:0]  causeReg, causeNext;
  logic        loadIr, retire, imemReqInt, levelActive;
  decodeT      dec;

  cpu16_main_decoder mainDecoder (
    .opcode (irReg[15:12]),
    .dec    (dec)
  );

  assign waitInc = waitCnt + 8'd1;
  assign pcNext  = (dec.is_branch && Zero) ? (BranchTarget & 16'hFFFE) : pcReg + 16'd2;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state      <= FETCH;
      pcReg      <= RESET_PC;
      irReg      <= '0;
      waitCnt    <= '0;
      retiredCnt <= '0;
      causeReg   <= TRAP_NONE;
    end else begin
      state    <= stateNext;
      waitCnt  <= waitNext;
      causeReg <= causeNext;
      if (loadIr) irReg <= ImemData;
      if (retire) begin
        pcReg      <= pcNext;
        retiredCnt <= retiredCnt + 16'd1;
      end
    end
  end

  // A ready arriving on the cycle the wait count would hit MAX_WAIT still wins.
  always_comb begin
    stateNext   = state;
    waitNext    = waitCnt;
    causeNext   = causeReg;
    loadIr      = 1'b0;
    retire      = 1'b0;
    imemReqInt  = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    MulRegWrite = 1'b0;
    case (state)
      FETCH: begin
        imemReqInt = 1'b1;
        if (ImemReady) begin
          loadIr    = 1'b1;
          stateNext = DECODE;
        end else if (waitInc == MAX_WAIT) begin
          stateNext = TRAP;
          causeNext = TRAP_BUS;
        end else begin
          waitNext = waitInc;
        end
      end
      DECODE: begin
        if (irReg[15:12] == OP_HALT) begin
          stateNext = HALT;
        end else if (dec.illegal) begin
          stateNext = TRAP;
          causeNext = TRAP_ILLEGAL;
        end else begin
          stateNext = EXEC;
        end
      end
      EXEC: begin
        if (dec.is_branch) begin
          retire = 1'b1;
        end else if (dec.is_mem) begin
          stateNext = MEM;
          waitNext  = '0;
        end else begin
          stateNext = WB;
        end
      end
      MEM: begin
        MemRead  = dec.is_load;
        MemWrite = !dec.is_load;
        if (DmemReady) begin
          if (dec.is_load) stateNext = WB;
          else retire = 1'b1;
        end else if (waitInc == MAX_WAIT) begin
          stateNext = TRAP;
          causeNext = TRAP_BUS;
        end else begin
          waitNext = waitInc;
        end
      end
      WB: begin
        RegWrite    = dec.writes_reg && !dec.is_mul;
        MulRegWrite = dec.is_mul;
        retire      = 1'b1;
      end
      default: stateNext = state;
    endcase
    if (retire) begin
      stateNext = FETCH;
      waitNext  = '0;
    end
  end

  assign levelActive = (state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB);

  // ImemReq is gated by ResetN so the fetch strobe drops the instant reset asserts.
  assign ImemReq      = imemReqInt && ResetN;
  assign ImemAddr     = pcReg;
  assign PC           = pcReg;
  assign Instruction  = irReg;
  assign RegDst       = levelActive && dec.regDst;
  assign Branch       = levelActive && dec.branch;
  assign MemToReg     = levelActive && dec.memToReg;
  assign ALUSrc       = levelActive && dec.aluSrc;
  assign ALUOp        = levelActive ? dec.aluOp : ALUOP_ADD;
  assign Halted       = (state == HALT);
  assign Trap         = (state == TRAP);
  assign TrapCause    = causeReg;
  assign RetiredCount = retiredCnt;

endmodule

// File: tb/tb_cpu16_multicycle_ctrl.sv
// Self-checking bench for cpu16_multicycle_ctrl: a table of single-instruction
// runs with hand-computed results, then directed halt/trap/timeout/reset sequences.
module tb_cpu16_multicycle_ctrl;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b1;
  logic        ImemReady = 1'b0;
  logic [15:0] ImemData = '0;
  logic        Zero = 1'b0;
  logic [15:0] BranchTarget = '0;
  logic        DmemReady = 1'b0;
  logic        ImemReq, RegDst, Branch, MemRead, MemWrite, MemToReg, ALUSrc;
  logic        RegWrite, MulRegWrite, Halted, Trap;
  logic [15:0] ImemAddr, Instruction, PC, RetiredCount;
  logic [1:0]  ALUOp, TrapCause;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [15:0] instr;
    logic        zero;
    logic [15:0] target;
    int          dmemDelay;
    logic [15:0] expPc;
    logic [15:0] expRet;
    int          expCycles;
    int          expRegW;
    int          expMulW;
    int          expMemR;
    int          expMemW;
    logic [5:0]  expLv;
    logic        expMtrWb;
  } vecT;

  typedef struct {
    int         cycles;
    int         regW;
    int         mulW;
    int         memR;
    int         memW;
    logic [5:0] lv;
    logic       mtrWb;
    logic       done;
  } resT;

  cpu16_multicycle_ctrl #(.RESET_PC(16'h0000), .MAX_WAIT(8'd4)) dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemReady    (ImemReady),
    .ImemData     (ImemData),
    .Instruction  (Instruction),
    .PC           (PC),
    .Zero         (Zero),
    .BranchTarget (BranchTarget),
    .DmemReady    (DmemReady),
    .RegDst       (RegDst),
    .Branch       (Branch),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemToReg     (MemToReg),
    .ALUSrc       (ALUSrc),
    .RegWrite     (RegWrite),
    .MulRegWrite  (MulRegWrite),
    .ALUOp        (ALUOp),
    .Halted       (Halted),
    .Trap         (Trap),
    .TrapCause    (TrapCause),
    .RetiredCount (RetiredCount)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyReset();
    ResetN = 1'b0;
    ImemReady = 1'b0;
    DmemReady = 1'b0;
    Zero = 1'b0;
    ImemData = '0;
    BranchTarget = '0;
    repeat (2) @(posedge Clock);
    #1;
    ResetN = 1'b1;
    #1;
  endtask

  // Feeds one instruction with a zero-wait fetch and a data memory that answers
  // after dmemDelay waiting cycles; runs until the next fetch, halt or trap.
  task automatic applyStimulus(input logic [15:0] instr, input logic zero, input logic [15:0] target,
                               input int dmemDelay, output resT r);
    int memWait;
    memWait = 0;
    r.cycles = 0; r.regW = 0; r.mulW = 0; r.memR = 0; r.memW = 0;
    r.lv = '0; r.mtrWb = 1'b0; r.done = 1'b0;
    ImemData = instr;
    Zero = zero;
    BranchTarget = target;
    for (int c = 0; c < 40; c++) begin
      ImemReady = (c == 0);
      DmemReady = 1'b0;
      #1;
      if (c == 1) r.lv = {RegDst, Branch, MemToReg, ALUSrc, ALUOp};
      if (RegWrite) begin
        r.regW++;
        r.mtrWb = MemToReg;
      end
      if (MulRegWrite) r.mulW++;
      if (MemRead) r.memR++;
      if (MemWrite) r.memW++;
      if (MemRead || MemWrite) begin
        DmemReady = (memWait == dmemDelay);
        memWait++;
      end
      @(posedge Clock);
      #1;
      r.cycles++;
      if (ImemReq || Halted || Trap) begin
        r.done = 1'b1;
        break;
      end
    end
    ImemReady = 1'b0;
    DmemReady = 1'b0;
    checkOutput("instrFinished", r.done, 1);
  endtask

  vecT vecs[12];
  resT res;
  int  trapAt;

  initial begin
    vecs[0]  = '{16'h4105, 1'b0, 16'h0000, 0, 16'h0002, 16'd1,  4, 1, 0, 0, 0, 6'b000100, 1'b0};
    vecs[1]  = '{16'h0123, 1'b0, 16'h0000, 0, 16'h0004, 16'd2,  4, 1, 0, 0, 0, 6'b100010, 1'b0};
    vecs[2]  = '{16'h1231, 1'b0, 16'h0000, 0, 16'h0006, 16'd3,  4, 0, 1, 0, 0, 6'b100010, 1'b0};
    vecs[3]  = '{16'hC204, 1'b0, 16'h0000, 0, 16'h0008, 16'd4,  4, 0, 0, 0, 1, 6'b000100, 1'b0};
    vecs[4]  = '{16'hC204, 1'b0, 16'h0000, 2, 16'h000A, 16'd5,  6, 0, 0, 0, 3, 6'b000100, 1'b0};
    vecs[5]  = '{16'h8302, 1'b0, 16'h0000, 0, 16'h000C, 16'd6,  5, 1, 0, 1, 0, 6'b001100, 1'b1};
    vecs[6]  = '{16'hD0F0, 1'b0, 16'h1234, 0, 16'h000E, 16'd7,  3, 0, 0, 0, 0, 6'b010001, 1'b0};
    vecs[7]  = '{16'hD0F0, 1'b1, 16'h0011, 0, 16'h0010, 16'd8,  3, 0, 0, 0, 0, 6'b010001, 1'b0};
    vecs[8]  = '{16'h8302, 1'b0, 16'h0000, 3, 16'h0012, 16'd9,  8, 1, 0, 4, 0, 6'b001100, 1'b1};
    vecs[9]  = '{16'hD0F0, 1'b1, 16'h0041, 0, 16'h0040, 16'd10, 3, 0, 0, 0, 0, 6'b010001, 1'b0};
    vecs[10] = '{16'hD0F0, 1'b1, 16'hFFFF, 0, 16'hFFFE, 16'd11, 3, 0, 0, 0, 0, 6'b010001, 1'b0};
    vecs[11] = '{16'h0456, 1'b0, 16'h0000, 0, 16'h0000, 16'd12, 4, 1, 0, 0, 0, 6'b100010, 1'b0};

    #2;
    ResetN = 1'b0;
    #1;
    checkOutput("rst imemReq", ImemReq, 0);
    checkOutput("rst pc", PC, 16'h0000);
    checkOutput("rst ir", Instruction, 16'h0000);
    checkOutput("rst retired", RetiredCount, 0);
    checkOutput("rst halted", Halted, 0);
    checkOutput("rst trap", Trap, 0);
    checkOutput("rst cause", TrapCause, 0);
    applyReset();
    checkOutput("post-rst imemReq", ImemReq, 1);
    checkOutput("post-rst imemAddr", ImemAddr, 16'h0000);
    checkOutput("fetch levels", {RegDst, Branch, MemToReg, ALUSrc, ALUOp}, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].zero, vecs[i].target, vecs[i].dmemDelay, res);
      checkOutput($sformatf("v%0d cycles", i), res.cycles, vecs[i].expCycles);
      checkOutput($sformatf("v%0d pc", i), PC, vecs[i].expPc);
      checkOutput($sformatf("v%0d imemAddr", i), ImemAddr, vecs[i].expPc);
      checkOutput($sformatf("v%0d retired", i), RetiredCount, vecs[i].expRet);
      checkOutput($sformatf("v%0d regWrite", i), res.regW, vecs[i].expRegW);
      checkOutput($sformatf("v%0d mulRegWrite", i), res.mulW, vecs[i].expMulW);
      checkOutput($sformatf("v%0d memRead", i), res.memR, vecs[i].expMemR);
      checkOutput($sformatf("v%0d memWrite", i), res.memW, vecs[i].expMemW);
      checkOutput($sformatf("v%0d levels", i), res.lv, vecs[i].expLv);
      checkOutput($sformatf("v%0d memToRegAtWb", i), res.mtrWb, vecs[i].expMtrWb);
    end
    checkOutput("table trap", Trap, 0);

    // Fetch ready arriving on the last allowed wait cycle must not trap.
    repeat (3) step();
    checkOutput("fetchWait imemReq", ImemReq, 1);
    applyStimulus(16'h4105, 1'b0, 16'h0000, 0, res);
    checkOutput("lateReady trap", Trap, 0);
    checkOutput("lateReady pc", PC, 16'h0002);
    checkOutput("lateReady retired", RetiredCount, 13);

    // Data memory never answers: bus timeout trap.
    applyStimulus(16'hC204, 1'b0, 16'h0000, 100, res);
    checkOutput("memTimeout cycles", res.cycles, 7);
    checkOutput("memTimeout memWrite", res.memW, 4);
    checkOutput("memTimeout trap", Trap, 1);
    checkOutput("memTimeout cause", TrapCause, 2'b10);
    checkOutput("memTimeout pc", PC, 16'h0002);
    step();
    checkOutput("memTimeout drop", MemWrite, 0);
    checkOutput("memTimeout halted", Halted, 0);

    // Reset asserted mid-MEM drops MemWrite without waiting for a clock.
    applyReset();
    checkOutput("trap cleared", Trap, 0);
    checkOutput("cause cleared", TrapCause, 0);
    ImemData = 16'hC204;
    ImemReady = 1'b1;
    step();
    ImemReady = 1'b0;
    step();
    step();
    checkOutput("midMem memWrite", MemWrite, 1);
    ResetN = 1'b0;
    #1;
    checkOutput("async memWrite", MemWrite, 0);
    checkOutput("async imemReq", ImemReq, 0);
    checkOutput("async aluSrc", ALUSrc, 0);

    // Illegal opcode 7.
    applyReset();
    applyStimulus(16'h7123, 1'b0, 16'h0000, 0, res);
    checkOutput("illegal cycles", res.cycles, 2);
    checkOutput("illegal trap", Trap, 1);
    checkOutput("illegal cause", TrapCause, 2'b01);
    checkOutput("illegal strobes", res.regW + res.mulW + res.memR + res.memW, 0);
    ImemData = 16'h4105;
    ImemReady = 1'b1;
    repeat (3) step();
    ImemReady = 1'b0;
    checkOutput("illegal imemReq", ImemReq, 0);
    checkOutput("illegal regWrite", RegWrite, 0);
    checkOutput("illegal pc", PC, 16'h0000);
    checkOutput("illegal ir", Instruction, 16'h7123);
    checkOutput("illegal halted", Halted, 0);

    // Fetch never ready: bus timeout after MAX_WAIT cycles.
    applyReset();
    trapAt = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (Trap) begin
        trapAt = k;
        break;
      end
    end
    checkOutput("fetchTimeout cycles", trapAt, 4);
    checkOutput("fetchTimeout cause", TrapCause, 2'b10);
    checkOutput("fetchTimeout imemReq", ImemReq, 0);

    // HALT is terminal and stops fetching.
    applyReset();
    applyStimulus(16'hF000, 1'b0, 16'h0000, 0, res);
    checkOutput("halt cycles", res.cycles, 2);
    checkOutput("halt halted", Halted, 1);
    ImemData = 16'h4105;
    ImemReady = 1'b1;
    repeat (3) step();
    ImemReady = 1'b0;
    checkOutput("halt imemReq", ImemReq, 0);
    checkOutput("halt pc", PC, 16'h0000);
    checkOutput("halt retired", RetiredCount, 0);
    checkOutput("halt still", Halted, 1);
    checkOutput("halt trap", Trap, 0);
    checkOutput("halt levels", {RegDst, Branch, MemToReg, ALUSrc, ALUOp}, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
